ctrl_pipe_unit: RTL and testbench
=================================

# ctrl_pipe_unit

Parametrised control path for the 5-stage RV32I pipeline. Decodes the D-stage instruction fields into datapath controls and carries them through ID/EX, EX/MEM and MEM/WB registers with stall and flush support. It resolves all six RV32I branch conditions in EX and registers the jalr select and memory access size per stage. An optional block of performance counters can be compiled in.

## Interface
- PERF_W, 16: width of each performance counter.
- PERF_SAT, 1: 1 = counters saturate at all-ones; 0 = counters wrap to 0.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- opcode  in  7  instruction[6:0] in D.
- funct3  in  3  instruction[14:12] in D.
- funct7bit5  in  1  instruction[30] in D.
- Zero_E, Lt_E, Ltu_E  in  1 each  ALU flags in EX: result zero, signed rs1<rs2, unsigned rs1<rs2.
- Stall_E  in  1  hold the ID/EX control register.
- Flush_E  in  1  load a bubble into ID/EX; has priority over Stall_E.
- ImmSrcD  out  3  immediate selector: 000 I, 001 S, 010 B, 011 J, 100 U.
- IllegalD  out  1  unsupported opcode or funct in D (combinational).
- ALUControlE  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 passB.
- ALUSrcAE  out  1  0 = rs1, 1 = PC.
- ALUSrcBE  out  2  00 = rs2, 01 = imm.
- ResultSrcE0  out  1  ResultSrcE[0], used for load-use detection.
- PCSrcE  out  1  redirect the PC (taken branch or jump).
- PCJalSrcE  out  1  target source is the ALU result (jalr).
- RegWriteM, MemWriteM  out  1 each  MEM-stage write enables.
- MemSizeM  out  3  funct3 of the load/store in MEM.
- RegWriteW  out  1  WB-stage register write enable.
- ResultSrcW  out  2  00 = ALU, 01 = memory, 10 = PC+4.
- BrTakenCnt, FlushCnt  out  PERF_W each  performance counters.

## Operation
- Decode in D (combinational):
  - R: ALUSrcB 00, RegWrite 1.
  - I-ALU: ALUSrcB 01, RegWrite 1.
  - load: add, ResultSrc 01.
  - store: add, MemWrite 1.
  - branch: sub, Branch 1.
  - jal: A = PC, B = imm, add, ResultSrc 10, Jump 1.
  - jalr: A = rs1, B = imm, add, ResultSrc 10, Jump 1, Jalr 1.
  - lui: passB.
  - auipc: A = PC, B = imm, add.
- ALU op from funct3/funct7bit5:
  - sub only when opcode[5] = 1 and funct7bit5 = 1.
  - sra when funct3 = 101 and funct7bit5 = 1.
- IllegalD is raised for:
  - unknown opcode;
  - branch with funct3 010 or 011;
  - load with funct3 011, 110 or 111;
  - store with funct3 above 010.
- When IllegalD = 1, all write, branch and jump controls are forced to 0.
- The ID/EX register holds RegWrite, MemWrite, Jump, Branch, Jalr, ALUSrcA, ALUSrcB, ResultSrc, ALUControl and funct3.
- Branch condition in EX (funct3E):
  - 000 Zero_E; 001 !Zero_E.
  - 100 Lt_E; 101 !Lt_E.
  - 110 Ltu_E; 111 !Ltu_E.
- PCSrcE = (BranchE & cond) | JumpE.
- PCJalSrcE = JumpE & JalrE. It is registered from decode, not taken from the live opcode.
- ID/EX update priority: reset > Flush_E (all zero) > Stall_E (hold) > load from D.
- EX/MEM:
  - Stall_E = 1 and Flush_E = 0: EX/MEM receives a bubble (RegWrite = 0, MemWrite = 0).
  - Otherwise EX/MEM captures the E values.
- MEM/WB always captures the M values.

## Timing
- Reset values: every registered output is 0, counters are 0, and PCSrcE = PCJalSrcE = 0.
- Latency: a D-stage decode reaches E 1 cycle later, M 2 cycles later and W 3 cycles later, absent stalls.
- PCSrcE is combinational from the E registers and the flags. It stays valid for every cycle E holds under Stall_E.
- Flush_E and Stall_E high together: the bubble wins.
- Reset asserted mid-instruction: all stages become bubbles on the next edge, regardless of Stall_E or Flush_E.

## Configuration
- CTRL_PERF_CNT_EN defined:
  - BrTakenCnt increments on each cycle with PCSrcE = 1 and Stall_E = 0.
  - FlushCnt increments on each cycle with Flush_E = 1.
  - At all-ones, counters saturate (PERF_SAT = 1) or wrap to 0 (PERF_SAT = 0).
- CTRL_PERF_CNT_EN undefined: both counters are tied to 0 and no counter flops exist.

## Test plan
- Reset check: reset high for 2 cycles with opcode = 0110011 -> all outputs 0. First instruction reaches W 3 cycles after release.
- Branch conditions: bltu (funct3 110) with Ltu_E = 1, Zero_E = 0 -> PCSrcE = 1. Same instruction with Ltu_E = 0 -> PCSrcE = 0. Repeat for all 6 funct3 codes.
- jalr (1100111): 1 cycle later PCSrcE = 1, PCJalSrcE = 1, ALUSrcAE = 0, ALUSrcBE = 01. Three cycles after decode ResultSrcW = 10 and RegWriteW = 1.
- Stall and flush: store held by Stall_E for 2 cycles -> MemWriteM = 0 for 2 cycles, then 1 for one cycle. Flush_E and Stall_E asserted together -> ALUControlE = 0000 and RegWriteE = 0 next cycle.
- Illegal decode: opcode 1100011, funct3 010 -> IllegalD = 1, ImmSrcD = 010, no PCSrcE in E.
- Counter saturation (CTRL_PERF_CNT_EN, PERF_W = 4, PERF_SAT = 1): 20 taken jal -> BrTakenCnt = 15. With PERF_SAT = 0 -> BrTakenCnt = 4.

Source files
------------

// File: rtl/ctrl_pipe_unit.sv
// RV32I control path: D-stage decode plus ID/EX, EX/MEM and MEM/WB control registers.
// Optional performance counters are compiled in with `define CTRL_PERF_CNT_EN.
module ctrl_pipe_unit #(
    parameter int unsigned PERF_W   = 16,
    parameter int unsigned PERF_SAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              funct7bit5,
    input  logic              Zero_E,
    input  logic              Lt_E,
    input  logic              Ltu_E,
    input  logic              Stall_E,
    input  logic              Flush_E,
    output logic [2:0]        ImmSrcD,
    output logic              IllegalD,
    output logic [3:0]        ALUControlE,
    output logic              ALUSrcAE,
    output logic [1:0]        ALUSrcBE,
    output logic              ResultSrcE0,
    output logic              PCSrcE,
    output logic              PCJalSrcE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [2:0]        MemSizeM,
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcW,
    output logic [PERF_W-1:0] BrTakenCnt,
    output logic [PERF_W-1:0] FlushCnt
);
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [3:0] AluAdd = 4'b0000, AluSub = 4'b0001, AluAnd = 4'b0010;
    localparam logic [3:0] AluOr = 4'b0011, AluXor = 4'b0100, AluSlt = 4'b0101;
    localparam logic [3:0] AluSltu = 4'b0110, AluSll = 4'b0111, AluSrl = 4'b1000;
    localparam logic [3:0] AluSra = 4'b1001, AluPassB = 4'b1010;

    logic       regWriteD, memWriteD, jumpD, branchD, jalrD, aluSrcAD, useFunct;
    logic [1:0] aluSrcBD, resultSrcD;
    logic [3:0] aluControlD;

    always_comb begin
        ImmSrcD     = 3'b000;
        IllegalD    = 1'b0;
        regWriteD   = 1'b0;
        memWriteD   = 1'b0;
        jumpD       = 1'b0;
        branchD     = 1'b0;
        jalrD       = 1'b0;
        aluSrcAD    = 1'b0;
        aluSrcBD    = 2'b00;
        resultSrcD  = 2'b00;
        aluControlD = AluAdd;
        useFunct    = 1'b0;
        case (opcode)
            OpR: begin
                regWriteD = 1'b1;
                useFunct  = 1'b1;
            end
            OpImm: begin
                regWriteD = 1'b1;
                aluSrcBD  = 2'b01;
                useFunct  = 1'b1;
            end
            OpLoad: begin
                regWriteD  = 1'b1;
                aluSrcBD   = 2'b01;
                resultSrcD = 2'b01;
                IllegalD   = funct3 inside {3'b011, 3'b110, 3'b111};
            end
            OpStore: begin
                ImmSrcD   = 3'b001;
                aluSrcBD  = 2'b01;
                memWriteD = 1'b1;
                IllegalD  = funct3 > 3'b010;
            end
            OpBranch: begin
                ImmSrcD     = 3'b010;
                branchD     = 1'b1;
                aluControlD = AluSub;
                IllegalD    = funct3 inside {3'b010, 3'b011};
            end
            OpJal: begin
                ImmSrcD    = 3'b011;
                regWriteD  = 1'b1;
                aluSrcAD   = 1'b1;
                aluSrcBD   = 2'b01;
                resultSrcD = 2'b10;
                jumpD      = 1'b1;
            end
            OpJalr: begin
                regWriteD  = 1'b1;
                aluSrcBD   = 2'b01;
                resultSrcD = 2'b10;
                jumpD      = 1'b1;
                jalrD      = 1'b1;
            end
            OpLui: begin
                ImmSrcD     = 3'b100;
                regWriteD   = 1'b1;
                aluSrcBD    = 2'b01;
                aluControlD = AluPassB;
            end
            OpAuipc: begin
                ImmSrcD   = 3'b100;
                regWriteD = 1'b1;
                aluSrcAD  = 1'b1;
                aluSrcBD  = 2'b01;
            end
            default: IllegalD = 1'b1;
        endcase
        if (useFunct) begin
            // funct7bit5 means sub only on register-register ops; on OP-IMM it is immediate data.
            case (funct3)
                3'b000:  aluControlD = (opcode[5] && funct7bit5) ? AluSub : AluAdd;
                3'b001:  aluControlD = AluSll;
                3'b010:  aluControlD = AluSlt;
                3'b011:  aluControlD = AluSltu;
                3'b100:  aluControlD = AluXor;
                3'b101:  aluControlD = funct7bit5 ? AluSra : AluSrl;
                3'b110:  aluControlD = AluOr;
                default: aluControlD = AluAnd;
            endcase
        end
        if (IllegalD) begin
            regWriteD = 1'b0;
            memWriteD = 1'b0;
            jumpD     = 1'b0;
            branchD   = 1'b0;
            jalrD     = 1'b0;
        end
    end

    logic       regWriteE, memWriteE, jumpE, branchE, jalrE;
    logic [1:0] resultSrcE, resultSrcM;
    logic [2:0] funct3E;

    always_ff @(posedge clk) begin
        if (reset || Flush_E) begin
            regWriteE   <= 1'b0;
            memWriteE   <= 1'b0;
            jumpE       <= 1'b0;
            branchE     <= 1'b0;
            jalrE       <= 1'b0;
            ALUSrcAE    <= 1'b0;
            ALUSrcBE    <= 2'b00;
            resultSrcE  <= 2'b00;
            ALUControlE <= 4'b0000;
            funct3E     <= 3'b000;
        end else if (!Stall_E) begin
            regWriteE   <= regWriteD;
            memWriteE   <= memWriteD;
            jumpE       <= jumpD;
            branchE     <= branchD;
            jalrE       <= jalrD;
            ALUSrcAE    <= aluSrcAD;
            ALUSrcBE    <= aluSrcBD;
            resultSrcE  <= resultSrcD;
            ALUControlE <= aluControlD;
            funct3E     <= funct3D();
        end
    end

    function automatic logic [2:0] funct3D();
        return funct3;
    endfunction

    assign ResultSrcE0 = resultSrcE[0];

    logic brCond;
    always_comb begin
        brCond = 1'b0;
        case (funct3E)
            3'b000:  brCond = Zero_E;
            3'b001:  brCond = !Zero_E;
            3'b100:  brCond = Lt_E;
            3'b101:  brCond = !Lt_E;
            3'b110:  brCond = Ltu_E;
            3'b111:  brCond = !Ltu_E;
            default: brCond = 1'b0;
        endcase
        PCSrcE    = (branchE & brCond) | jumpE;
        PCJalSrcE = jumpE & jalrE;
    end

    // A stalled E instruction must not also appear in MEM, so writes are suppressed there.
    logic mBubble;
    assign mBubble = Stall_E & ~Flush_E;

    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemSizeM   <= 3'b000;
            resultSrcM <= 2'b00;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
        end else begin
            RegWriteM  <= regWriteE & ~mBubble;
            MemWriteM  <= memWriteE & ~mBubble;
            MemSizeM   <= funct3E;
            resultSrcM <= resultSrcE;
            RegWriteW  <= RegWriteM;
            ResultSrcW <= resultSrcM;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    localparam logic [PERF_W-1:0] CntOne = {{(PERF_W - 1){1'b0}}, 1'b1};

    function automatic logic [PERF_W-1:0] bump(input logic [PERF_W-1:0] c);
        if ((PERF_SAT != 0) && (&c)) return c;
        return c + CntOne;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            BrTakenCnt <= '0;
            FlushCnt   <= '0;
        end else begin
            if (PCSrcE && !Stall_E) BrTakenCnt <= bump(BrTakenCnt);
            if (Flush_E) FlushCnt <= bump(FlushCnt);
        end
    end
`else
    logic unusedPerfSat;
    assign unusedPerfSat = (PERF_SAT != 0);
    assign BrTakenCnt    = '0;
    assign FlushCnt      = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit: decode table scoreboard through E/M/W,
// branch conditions, stall/flush behaviour, mid-run reset and counters.
module tb_ctrl_pipe_unit;
    localparam int unsigned PW = 4;
`ifdef CTRL_PERF_CNT_EN
    localparam logic [PW-1:0] ExpBr = 4'd15;
    localparam logic [PW-1:0] ExpFl = 4'd3;
`else
    localparam logic [PW-1:0] ExpBr = 4'd0;
    localparam logic [PW-1:0] ExpFl = 4'd0;
`endif

    logic          clk = 1'b0;
    logic          reset, funct7bit5, Zero_E, Lt_E, Ltu_E, Stall_E, Flush_E;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [2:0]    ImmSrcD, MemSizeM;
    logic          IllegalD, ALUSrcAE, ResultSrcE0, PCSrcE, PCJalSrcE;
    logic          RegWriteM, MemWriteM, RegWriteW;
    logic [3:0]    ALUControlE;
    logic [1:0]    ALUSrcBE, ResultSrcW;
    logic [PW-1:0] BrTakenCnt, FlushCnt;

    ctrl_pipe_unit #(.PERF_W(PW), .PERF_SAT(1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7bit5(funct7bit5),
        .Zero_E(Zero_E), .Lt_E(Lt_E), .Ltu_E(Ltu_E), .Stall_E(Stall_E), .Flush_E(Flush_E),
        .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .ALUControlE(ALUControlE),
        .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .ResultSrcE0(ResultSrcE0),
        .PCSrcE(PCSrcE), .PCJalSrcE(PCJalSrcE), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .MemSizeM(MemSizeM), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .BrTakenCnt(BrTakenCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [2:0] imm;
        logic       ill;
        logic [3:0] alu;
        logic       a;
        logic [1:0] b;
        logic       pcs;
        logic       jl;
        logic       rw;
        logic       mw;
        logic [1:0] rs;
    } vec_t;

    vec_t vecs[$];
    vec_t qE[$], qM[$], qW[$];
    vec_t v;
    int   nVec = 0;
    int   nMis = 0;

    logic [2:0] brF3[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    // {Zero_E, Lt_E, Ltu_E} that makes each branch taken; the complement makes it not taken.
    logic [2:0] brT[6]  = '{3'b100, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode     = op;
        funct3     = f3;
        funct7bit5 = f7;
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic [2:0] imm, input logic ill, input logic [3:0] alu,
                                input logic a, input logic [1:0] b, input logic pcs,
                                input logic jl, input logic rw, input logic mw,
                                input logic [1:0] rs);
        return '{op, f3, f7, imm, ill, alu, a, b, pcs, jl, rw, mw, rs};
    endfunction

    initial begin
        reset = 1'b1;
        {Zero_E, Lt_E, Ltu_E, Stall_E, Flush_E} = 5'b0;
        drive(7'h33, 3'd0, 1'b0);
        step();
        step();
        chk("rstAluE", ALUControlE, 4'd0);
        chk("rstSrcA", ALUSrcAE, 1'b0);
        chk("rstSrcB", ALUSrcBE, 2'd0);
        chk("rstRsE0", ResultSrcE0, 1'b0);
        chk("rstPcs", PCSrcE, 1'b0);
        chk("rstJal", PCJalSrcE, 1'b0);
        chk("rstRwM", RegWriteM, 1'b0);
        chk("rstMwM", MemWriteM, 1'b0);
        chk("rstSize", MemSizeM, 3'd0);
        chk("rstRwW", RegWriteW, 1'b0);
        chk("rstRsW", ResultSrcW, 2'd0);
        chk("rstBrCnt", BrTakenCnt, 4'd0);
        chk("rstFlCnt", FlushCnt, 4'd0);
        chk("rstIll", IllegalD, 1'b0);
        reset = 1'b0;
        step();
        step();
        chk("firstW2", RegWriteW, 1'b0);
        step();
        chk("firstW3", RegWriteW, 1'b1);

        //             op     f3    f7    imm   ill   alu    a     b     pcs   jl    rw    mw    rs
        vecs.push_back(mk(7'h33, 3'd0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(7'h33, 3'd0, 1'b1, 3'd0, 1'b0, 4'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(7'h33, 3'd5, 1'b1, 3'd0, 1'b0, 4'd9, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(7'h33, 3'd5, 1'b0, 3'd0, 1'b0, 4'd8, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(7'h33, 3'd7, 1'b0, 3'd0, 1'b0, 4'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(7'h13, 3'd0, 1'b1, 3'd0, 1'b0, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(7'h13, 3'd5, 1'b1, 3'd0, 1'b0, 4'd9, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(7'h13, 3'd1, 1'b0, 3'd0, 1'b0, 4'd7, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(7'h13, 3'd2, 1'b0, 3'd0, 1'b0, 4'd5, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(7'h13, 3'd3, 1'b0, 3'd0, 1'b0, 4'd6, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(7'h13, 3'd4, 1'b0, 3'd0, 1'b0, 4'd4, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(7'h13, 3'd6, 1'b0, 3'd0, 1'b0, 4'd3, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(7'h03, 3'd2, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1));
        vecs.push_back(mk(7'h03, 3'd4, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1));
        vecs.push_back(mk(7'h23, 3'd2, 1'b0, 3'd1, 1'b0, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        vecs.push_back(mk(7'h23, 3'd0, 1'b0, 3'd1, 1'b0, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        vecs.push_back(mk(7'h63, 3'd1, 1'b0, 3'd2, 1'b0, 4'd1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        vecs.push_back(mk(7'h63, 3'd0, 1'b0, 3'd2, 1'b0, 4'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        vecs.push_back(mk(7'h6f, 3'd0, 1'b0, 3'd3, 1'b0, 4'd0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2));
        vecs.push_back(mk(7'h67, 3'd0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2));
        vecs.push_back(mk(7'h37, 3'd0, 1'b0, 3'd4, 1'b0, 4'd10, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(7'h17, 3'd0, 1'b0, 3'd4, 1'b0, 4'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(7'h7f, 3'd0, 1'b0, 3'd0, 1'b1, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        vecs.push_back(mk(7'h63, 3'd2, 1'b0, 3'd2, 1'b1, 4'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        vecs.push_back(mk(7'h03, 3'd6, 1'b0, 3'd0, 1'b1, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
        vecs.push_back(mk(7'h23, 3'd3, 1'b0, 3'd1, 1'b1, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));

        // Streaming pass, flags all low: E/M/W expectations are queued at issue and retired in order.
        for (int k = 0; k < vecs.size() + 2; k++) begin
            if (k < vecs.size()) begin
                v = vecs[k];
                drive(v.op, v.f3, v.f7);
                #1;
                chk("immSrcD", ImmSrcD, v.imm);
                chk("illegalD", IllegalD, v.ill);
                qE.push_back(v);
                qM.push_back(v);
                qW.push_back(v);
            end else begin
                drive(7'h33, 3'd0, 1'b0);
            end
            step();
            if (k < vecs.size()) begin
                v = qE.pop_front();
                chk("aluCtlE", ALUControlE, v.alu);
                chk("srcAE", ALUSrcAE, v.a);
                chk("srcBE", ALUSrcBE, v.b);
                chk("rsE0", ResultSrcE0, v.rs[0]);
                chk("pcSrcE", PCSrcE, v.pcs);
                chk("pcJalE", PCJalSrcE, v.jl);
            end
            if (k >= 1 && qM.size() > 0) begin
                v = qM.pop_front();
                chk("regWrM", RegWriteM, v.rw);
                chk("memWrM", MemWriteM, v.mw);
                chk("memSizeM", MemSizeM, v.f3);
            end
            if (k >= 2 && qW.size() > 0) begin
                v = qW.pop_front();
                chk("regWrW", RegWriteW, v.rw);
                chk("resSrcW", ResultSrcW, v.rs);
            end
        end

        for (int i = 0; i < 6; i++) begin
            drive(7'h63, brF3[i], 1'b0);
            step();
            {Zero_E, Lt_E, Ltu_E} = brT[i];
            #1;
            chk("brTaken", PCSrcE, 1'b1);
            {Zero_E, Lt_E, Ltu_E} = ~brT[i];
            #1;
            chk("brNotTaken", PCSrcE, 1'b0);
        end
        {Zero_E, Lt_E, Ltu_E} = 3'b000;

        drive(7'h23, 3'd2, 1'b0);
        step();
        drive(7'h33, 3'd0, 1'b0);
        Stall_E = 1'b1;
        step();
        chk("stallMw1", MemWriteM, 1'b0);
        chk("stallHoldB", ALUSrcBE, 2'd1);
        step();
        chk("stallMw2", MemWriteM, 1'b0);
        Stall_E = 1'b0;
        step();
        chk("stallMwGo", MemWriteM, 1'b1);
        chk("stallSize", MemSizeM, 3'd2);
        step();
        chk("stallMwDone", MemWriteM, 1'b0);

        drive(7'h63, 3'd1, 1'b0);
        step();
        chk("bneE", PCSrcE, 1'b1);
        drive(7'h33, 3'd0, 1'b0);
        Stall_E = 1'b1;
        step();
        chk("bneHeld", PCSrcE, 1'b1);
        Stall_E = 1'b0;

        drive(7'h33, 3'd0, 1'b1);
        step();
        chk("subE", ALUControlE, 4'd1);
        Flush_E = 1'b1;
        Stall_E = 1'b1;
        step();
        chk("flStAlu", ALUControlE, 4'd0);
        chk("flStSrcB", ALUSrcBE, 2'd0);
        chk("flStRwM", RegWriteM, 1'b1);
        Flush_E = 1'b0;
        Stall_E = 1'b0;
        drive(7'h37, 3'd0, 1'b0);
        step();
        chk("bubbleRwM", RegWriteM, 1'b0);
        chk("luiE", ALUControlE, 4'd10);
        step();
        step();
        chk("luiW", RegWriteW, 1'b1);

        reset   = 1'b1;
        Stall_E = 1'b1;
        step();
        chk("midRstAlu", ALUControlE, 4'd0);
        chk("midRstRwM", RegWriteM, 1'b0);
        chk("midRstRwW", RegWriteW, 1'b0);
        chk("midRstRsW", ResultSrcW, 2'd0);
        chk("midRstBr", BrTakenCnt, 4'd0);
        chk("midRstFl", FlushCnt, 4'd0);
        reset   = 1'b0;
        Stall_E = 1'b0;

        drive(7'h6f, 3'd0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        drive(7'h33, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        chk("brTakenCnt", BrTakenCnt, ExpBr);
        Flush_E = 1'b1;
        for (int i = 0; i < 3; i++) step();
        Flush_E = 1'b0;
        step();
        chk("flushCnt", FlushCnt, ExpFl);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
